// File: rtl/wb_pkg.sv
// Shared Wishbone constants and state encoding for the pixel-to-Wishbone DMA.
// Addresses are word-granular; the two byte-offset bits are never carried.
package wb_pkg;

   localparam int WB_ADR_W       = 32;
   localparam int WB_DAT_W       = 32;
   localparam int WB_SEL_W       = WB_DAT_W / 8;
   localparam int PIX_BYTES      = WB_DAT_W / 8;
   localparam int WB_TIMEOUT_DEF = 255;

   localparam logic [WB_SEL_W-1:0] WB_SEL_ALL  = '1;
   localparam logic [WB_SEL_W-1:0] WB_SEL_NONE = '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2
   } dma_state_t;

   // Byte address of word idx relative to a word-aligned base; wraps modulo 2^32.
   function automatic logic [WB_ADR_W-1:0] word_adr(input logic [WB_ADR_W-3:0] base_w,
                                                    input logic [15:0]         idx);
      return {base_w, 2'b00} + {{(WB_ADR_W-18){1'b0}}, idx, 2'b00};
   endfunction

endpackage

// File: rtl/pix_pack.sv
// Collects four pixel bytes into one big-endian 32-bit word.
// last flags the beat that completes the word.
module pix_pack
   import wb_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                accept,
   input  logic [7:0]          pix_dat,
   output logic [WB_DAT_W-1:0] word,
   output logic                last
);

   logic [1:0] byte_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         byte_cnt_reg <= 2'd0;
      end else if (accept) begin
         byte_cnt_reg <= byte_cnt_reg + 2'd1;
      end
   end

   assign last = accept && (byte_cnt_reg == 2'(PIX_BYTES - 1));

   // Lane 0 holds the first byte of the word and maps to the most significant bits.
   genvar gi;
   generate
      for (gi = 0; gi < PIX_BYTES; gi++) begin : g_lane
         logic [7:0] lane_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               lane_reg <= 8'd0;
            end else if (accept && (byte_cnt_reg == 2'(gi))) begin
               lane_reg <= pix_dat;
            end
         end

         assign word[WB_DAT_W-1-8*gi -: 8] = lane_reg;
      end
   endgenerate

endmodule

// File: rtl/wb_pix_dma.sv
// Streams camera bytes into 32-bit words and writes them to consecutive
// Wishbone addresses with classic single writes and an ack timeout.
module wb_pix_dma
   import wb_pkg::*;
#(
   parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WB_ADR_W-1:0] base_adr,
   input  logic [15:0]         word_cnt,
   input  logic [7:0]          pix_dat,
   input  logic                pix_valid,
   output logic                pix_ready,
   output logic [WB_ADR_W-1:0] wb_adr_o,
   output logic [WB_DAT_W-1:0] wb_dat_o,
   output logic [WB_SEL_W-1:0] wb_sel_o,
   output logic                wb_we_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   input  logic                wb_ack_i,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   dma_state_t          state_reg, state_next;
   logic [WB_ADR_W-3:0] base_reg;
   logic [15:0]         cnt_reg;
   logic [15:0]         idx_reg;
   logic [WAIT_W-1:0]   wait_reg;
   logic                zero_reg;
   logic                done_reg;
   logic                err_reg;

   logic                in_write;
   logic                pix_accept;
   logic                pack_clr;
   logic                pack_last;
   logic                last_word;
   logic                wait_expired;
   logic                done_set;
   logic                err_set;
   logic [WB_DAT_W-1:0] pack_word;
   logic                adr_lsb_unused;

   assign adr_lsb_unused = ^base_adr[1:0];

   assign in_write     = (state_reg == ST_WRITE);
   assign pix_ready    = (state_reg == ST_FILL) && !zero_reg;
   assign pix_accept   = pix_valid && pix_ready;
   assign last_word    = ((idx_reg + 16'd1) == cnt_reg);
   assign wait_expired = (wait_reg == WAIT_LAST);

   pix_pack u_pack (
      .clk     (clk),
      .rst     (rst),
      .clr     (pack_clr),
      .accept  (pix_accept),
      .pix_dat (pix_dat),
      .word    (pack_word),
      .last    (pack_last)
   );

   // A zero-length request passes through FILL for one cycle with the
   // pixel port closed so that busy is visible while done is pulsed.
   always_comb begin
      state_next = state_reg;
      done_set   = 1'b0;
      err_set    = 1'b0;
      pack_clr   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_FILL;
               pack_clr   = 1'b1;
               done_set   = (word_cnt == 16'd0);
            end
         end
         ST_FILL: begin
            if (zero_reg) begin
               state_next = ST_IDLE;
            end else if (pack_last) begin
               state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (wb_ack_i) begin
               state_next = last_word ? ST_IDLE : ST_FILL;
               done_set   = last_word;
            end else if (wait_expired) begin
               state_next = ST_IDLE;
               err_set    = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         base_reg  <= '0;
         cnt_reg   <= 16'd0;
         idx_reg   <= 16'd0;
         wait_reg  <= '0;
         zero_reg  <= 1'b0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_set;
         err_reg   <= err_set;
         case (state_reg)
            ST_IDLE: begin
               wait_reg <= '0;
               if (start) begin
                  base_reg <= base_adr[WB_ADR_W-1:2];
                  cnt_reg  <= word_cnt;
                  idx_reg  <= 16'd0;
                  zero_reg <= (word_cnt == 16'd0);
               end
            end
            ST_WRITE: begin
               if (wb_ack_i) begin
                  idx_reg  <= idx_reg + 16'd1;
                  wait_reg <= '0;
               end else if (wait_expired) begin
                  wait_reg <= '0;
               end else begin
                  wait_reg <= wait_reg + WAIT_W'(1);
               end
            end
            default: begin
               wait_reg <= '0;
            end
         endcase
      end
   end

   // Bus outputs derive from registered state only, so they hold steady through wait states.
   assign wb_cyc_o = in_write;
   assign wb_stb_o = in_write;
   assign wb_we_o  = in_write;
   assign wb_sel_o = in_write ? WB_SEL_ALL : WB_SEL_NONE;
   assign wb_adr_o = word_adr(base_reg, idx_reg);
   assign wb_dat_o = pack_word;
   assign busy     = (state_reg != ST_IDLE);
   assign done     = done_reg;
   assign err      = err_reg;

endmodule

// File: tb/tb_wb_pix_dma.sv
// Directed bench for wb_pix_dma: a pixel source, an ack-delay Wishbone slave
// and a write scoreboard filled as each transfer is launched.
`timescale 1ns/1ps
module tb_wb_pix_dma;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_adr;
   logic [15:0] word_cnt;
   logic [7:0]  pix_dat;
   logic        pix_valid;
   logic        pix_ready;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   wb_pix_dma #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_adr  (base_adr),
      .word_cnt  (word_cnt),
      .pix_dat   (pix_dat),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_sel_o  (wb_sel_o),
      .wb_we_o   (wb_we_o),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_ack_i  (wb_ack_i),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   wr_t exp_q[$];
   wr_t e;
   int  chk_cnt  = 0;
   int  pass_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      chk_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Wishbone slave and bus monitor
   int          done_cnt = 0, err_cnt = 0, cyc_cycles = 0, busy_cycles = 0, wait_n = 0;
   int          ack_delay = 0;
   bit          no_ack = 1'b0;
   logic [31:0] cap_adr, cap_dat;

   always @(negedge clk) begin
      wb_ack_i = 1'b0;
      if (!rst) begin
         if (done) done_cnt++;
         if (err)  err_cnt++;
         if (busy) busy_cycles++;
         if (wb_cyc_o || wb_stb_o) begin
            cyc_cycles++;
            check("cyc_eq_stb", 64'(wb_stb_o), 64'(wb_cyc_o));
            check("ready_in_write", 64'(pix_ready), 64'd0);
            if (wait_n == 0) begin
               cap_adr = wb_adr_o;
               cap_dat = wb_dat_o;
            end else begin
               check("adr_stable", 64'(wb_adr_o), 64'(cap_adr));
               check("dat_stable", 64'(wb_dat_o), 64'(cap_dat));
            end
            if (!no_ack && wait_n == ack_delay) begin
               wb_ack_i = 1'b1;
               check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("wr_adr", 64'(wb_adr_o), 64'(e.adr));
                  check("wr_dat", 64'(wb_dat_o), 64'(e.dat));
               end
               check("wr_sel", 64'(wb_sel_o), 64'hF);
               check("wr_we", 64'(wb_we_o), 64'd1);
               $display("write adr=%08h dat=%08h sel=%h waits=%0d", wb_adr_o, wb_dat_o, wb_sel_o, wait_n);
            end
            wait_n++;
         end else begin
            wait_n = 0;
         end
      end
   end

   // Pixel source: offers pix_mem[pix_pos], advancing only after a handshake.
   logic [7:0] pix_mem [0:63];
   int         pix_len = 0, pix_pos = 0;
   bit         pend_acc = 1'b0, toggle = 1'b0;

   always @(negedge clk) begin
      if (pend_acc) pix_pos++;
      if (pix_pos < pix_len && (!toggle || $urandom_range(0, 1) == 1)) begin
         pix_valid = 1'b1;
         pix_dat   = pix_mem[pix_pos];
      end else begin
         pix_valid = 1'b0;
         pix_dat   = 8'($urandom);
      end
      pend_acc = pix_valid && pix_ready;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_seq(input int n, input int first);
      for (int i = 0; i < n; i++) pix_mem[i] = 8'(first + i);
      pix_len  = n;
      pix_pos  = 0;
      pend_acc = 1'b0;
   endtask

   task automatic load_rand(input int n);
      for (int i = 0; i < n; i++) pix_mem[i] = 8'($urandom);
      pix_len  = n;
      pix_pos  = 0;
      pend_acc = 1'b0;
   endtask

   function automatic logic [31:0] mem_word(input int w);
      return {pix_mem[4*w], pix_mem[4*w+1], pix_mem[4*w+2], pix_mem[4*w+3]};
   endfunction

   task automatic push_exp(input logic [31:0] base, input int cnt);
      wr_t t;
      for (int w = 0; w < cnt; w++) begin
         t.adr = {base[31:2], 2'b00} + 32'(4 * w);
         t.dat = mem_word(w);
         exp_q.push_back(t);
      end
   endtask

   task automatic clear_stats();
      done_cnt    = 0;
      err_cnt     = 0;
      cyc_cycles  = 0;
      busy_cycles = 0;
   endtask

   task automatic kick(input logic [31:0] base, input logic [15:0] cnt);
      base_adr = base;
      word_cnt = cnt;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   task automatic wait_end();
      for (int i = 0; i < 500 && (done_cnt + err_cnt) == 0; i++) step();
      step();
      check("xfer_end", 64'(done_cnt + err_cnt), 64'd1);
   endtask

   initial begin
      wr_t t;
      rst      = 1'b1;
      start    = 1'b0;
      base_adr = 32'h0;
      word_cnt = 16'd0;
      wb_ack_i = 1'b0;
      repeat (3) step();
      check("rst_ready", 64'(pix_ready), 64'd0);
      check("rst_cyc", 64'(wb_cyc_o), 64'd0);
      check("rst_stb", 64'(wb_stb_o), 64'd0);
      check("rst_we", 64'(wb_we_o), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_adr", 64'(wb_adr_o), 64'd0);
      check("rst_dat", 64'(wb_dat_o), 64'd0);
      check("rst_sel", 64'(wb_sel_o), 64'd0);
      rst = 1'b0;
      step();

      // two words, zero-wait ack, full-rate pixels
      clear_stats();
      load_seq(8, 1);
      t.adr = 32'h0000_0100; t.dat = 32'h0102_0304; exp_q.push_back(t);
      t.adr = 32'h0000_0104; t.dat = 32'h0506_0708; exp_q.push_back(t);
      ack_delay = 0; no_ack = 1'b0; toggle = 1'b0;
      kick(32'h0000_0100, 16'd2);
      wait_end();
      check("basic_done", 64'(done_cnt), 64'd1);
      check("basic_err", 64'(err_cnt), 64'd0);
      check("basic_q", 64'(exp_q.size()), 64'd0);
      check("basic_busy_cycles", 64'(busy_cycles), 64'd10);
      check("basic_busy_end", 64'(busy), 64'd0);

      // zero-length request
      clear_stats();
      kick(32'h0000_0200, 16'd0);
      check("zero_done_pulse", 64'(done), 64'd1);
      check("zero_busy_pulse", 64'(busy), 64'd1);
      check("zero_ready", 64'(pix_ready), 64'd0);
      step();
      check("zero_done_low", 64'(done), 64'd0);
      check("zero_busy_low", 64'(busy), 64'd0);
      repeat (3) step();
      check("zero_cyc_cycles", 64'(cyc_cycles), 64'd0);
      check("zero_done_cnt", 64'(done_cnt), 64'd1);
      check("zero_busy_cycles", 64'(busy_cycles), 64'd1);

      // 3-cycle ack delay, gappy pixels, unaligned base, start while busy ignored
      clear_stats();
      load_rand(12);
      push_exp(32'h0000_2003, 3);
      ack_delay = 3; toggle = 1'b1;
      kick(32'h0000_2003, 16'd3);
      repeat (3) step();
      kick(32'h0000_5000, 16'd5);
      wait_end();
      check("wait_done", 64'(done_cnt), 64'd1);
      check("wait_err", 64'(err_cnt), 64'd0);
      check("wait_q", 64'(exp_q.size()), 64'd0);
      check("wait_bytes_used", 64'(pix_pos), 64'd12);
      toggle = 1'b0;

      // no ack: abort after TO cycles
      clear_stats();
      load_seq(4, 8'h40);
      no_ack = 1'b1;
      kick(32'h0000_0300, 16'd1);
      wait_end();
      check("to_cyc_cycles", 64'(cyc_cycles), 64'(TO));
      check("to_err", 64'(err_cnt), 64'd1);
      check("to_done", 64'(done_cnt), 64'd0);
      check("to_busy", 64'(busy), 64'd0);
      check("to_cyc_low", 64'(wb_cyc_o), 64'd0);
      no_ack = 1'b0;

      // address wrap
      clear_stats();
      load_seq(8, 8'hA0);
      t.adr = 32'hFFFF_FFFC; t.dat = mem_word(0); exp_q.push_back(t);
      t.adr = 32'h0000_0000; t.dat = mem_word(1); exp_q.push_back(t);
      ack_delay = 1;
      kick(32'hFFFF_FFFC, 16'd2);
      wait_end();
      check("wrap_done", 64'(done_cnt), 64'd1);
      check("wrap_q", 64'(exp_q.size()), 64'd0);

      // reset during WRITE, then a fresh transfer
      clear_stats();
      load_seq(8, 8'h10);
      no_ack = 1'b1;
      kick(32'h0000_0400, 16'd2);
      for (int i = 0; i < 50 && !wb_cyc_o; i++) step();
      check("pre_rst_cyc", 64'(wb_cyc_o), 64'd1);
      rst = 1'b1;
      step();
      check("mid_rst_cyc", 64'(wb_cyc_o), 64'd0);
      check("mid_rst_stb", 64'(wb_stb_o), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_err", 64'(err), 64'd0);
      rst = 1'b0;
      no_ack = 1'b0;
      repeat (5) step();
      check("post_rst_done_cnt", 64'(done_cnt), 64'd0);
      check("post_rst_err_cnt", 64'(err_cnt), 64'd0);
      clear_stats();
      load_seq(4, 8'h77);
      push_exp(32'h0000_0500, 1);
      ack_delay = 0;
      kick(32'h0000_0500, 16'd1);
      wait_end();
      check("fresh_done", 64'(done_cnt), 64'd1);
      check("fresh_q", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
